// File: rtl/scan_pkg.sv
// Shared types and default sizing for the scan chain controller.
package scan_pkg;

  localparam int SCAN_CHAIN_LEN      = 8;
  localparam int SCAN_CAPTURE_CYCLES = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_IN  = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_SHIFT_OUT = 3'd3,
    ST_DONE      = 3'd4
  } scan_state_t;

endpackage

// File: rtl/scan_shift_reg.sv
// Generic shift register: parallel load, shifts toward bit 0.
// Used as PISO (read bit 0 as serial out) and as SIPO (first sample
// shifted in ends up in bit 0 after WIDTH shifts).
module scan_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // Load has priority over shift; new serial bits enter at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= {WIDTH{1'b0}};
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_i) begin
      data_q <= {sin_i, data_q[WIDTH-1:1]};
    end else begin
      data_q <= data_q;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan test controller: shifts a pattern into the chain, captures for a
// configurable number of functional cycles, shifts the response out and
// reports a masked pass/fail verdict.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int CHAIN_LEN      = SCAN_CHAIN_LEN,
  parameter int CAPTURE_CYCLES = SCAN_CAPTURE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic [CHAIN_LEN-1:0] exp_data,
  input  logic [CHAIN_LEN-1:0] exp_mask,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [CHAIN_LEN-1:0] resp_data,
  output logic                 resp_fail,
  output logic                 busy,
  output logic                 scan_enable,
  output logic                 scan_in,
  input  logic                 scan_out
);

  localparam int             CW        = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0]  CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE   = CW'(32'd1);
  localparam logic [CW-1:0]  CNT_CHAIN = CW'(CHAIN_LEN);
  localparam logic [CW-1:0]  CNT_CAP   = CW'(CAPTURE_CYCLES);

  scan_state_t          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] exp_q, mask_q;
  logic                 scan_enable_q, scan_enable_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_fail_q, resp_fail_d;
  logic                 accept_s;
  logic [CHAIN_LEN-1:0] piso_q, sipo_q, sipo_next_s;
  logic [CHAIN_LEN-2:0] piso_unused_s;

  function automatic logic masked_fail(input logic [CHAIN_LEN-1:0] resp,
                                       input logic [CHAIN_LEN-1:0] expv,
                                       input logic [CHAIN_LEN-1:0] mask);
    return |((resp ^ expv) & mask);
  endfunction

  assign accept_s    = pat_valid && (state_q == ST_IDLE);
  assign sipo_next_s = {scan_out, sipo_q[CHAIN_LEN-1:1]};

  // Stimulus PISO: bit 0 drives scan_in directly; it drains to zeros
  // after CHAIN_LEN shifts, so scan_in stays 0 outside SHIFT_IN.
  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_piso (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept_s),
    .load_data_i (pat_data),
    .shift_i     (state_q == ST_SHIFT_IN),
    .sin_i       (1'b0),
    .q_o         (piso_q)
  );

  // Response SIPO: samples scan_out on every SHIFT_OUT edge.
  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_sipo (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept_s),
    .load_data_i ({CHAIN_LEN{1'b0}}),
    .shift_i     (state_q == ST_SHIFT_OUT),
    .sin_i       (scan_out),
    .q_o         (sipo_q)
  );

  assign piso_unused_s = piso_q[CHAIN_LEN-1:1];

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != CNT_ZERO) ? (cnt_q - CNT_ONE) : CNT_ZERO;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SHIFT_IN;
          cnt_d   = CNT_CHAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT_IN: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_CAPTURE;
          cnt_d   = CNT_CAP;
        end else begin
          state_d = ST_SHIFT_IN;
        end
      end
      ST_CAPTURE: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_SHIFT_OUT;
          cnt_d   = CNT_CHAIN;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_SHIFT_OUT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT_OUT;
        end
      end
      ST_DONE: begin
        if (resp_valid_q && resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Outputs follow the next state so they change on the same edge.
    scan_enable_d = (state_d == ST_SHIFT_IN) || (state_d == ST_SHIFT_OUT);
    resp_valid_d  = (state_d == ST_DONE);
    if (accept_s) begin
      resp_fail_d = 1'b0;
    end else if ((state_q == ST_SHIFT_OUT) && (state_d == ST_DONE)) begin
      resp_fail_d = masked_fail(sipo_next_s, exp_q, mask_q);
    end else begin
      resp_fail_d = resp_fail_q;
    end
  end

  // State, counter, latched expectation and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      exp_q         <= {CHAIN_LEN{1'b0}};
      mask_q        <= {CHAIN_LEN{1'b0}};
      scan_enable_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_fail_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      scan_enable_q <= scan_enable_d;
      resp_valid_q  <= resp_valid_d;
      resp_fail_q   <= resp_fail_d;
      if (accept_s) begin
        exp_q  <= exp_data;
        mask_q <= exp_mask;
      end else begin
        exp_q  <= exp_q;
        mask_q <= mask_q;
      end
    end
  end

  assign scan_enable = scan_enable_q;
  assign scan_in     = piso_q[0];
  assign resp_valid  = resp_valid_q;
  assign resp_data   = sipo_q;
  assign resp_fail   = resp_fail_q;
  assign pat_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);

endmodule
